// File: rtl/spi_reg_pkg.sv
// Shared constants, frame field positions and FSM state type for the SPI write-capture block.
package spi_reg_pkg;

    localparam int unsigned FRAME_BITS = 16;
    localparam int unsigned CNT_W      = 5;
    localparam int unsigned CNT_SAT    = 17;
    localparam logic        RW_WRITE   = 1'b1;

    localparam int unsigned RW_BIT     = 15;
    localparam int unsigned ADDR_LSB   = 8;
    localparam int unsigned DATA_LSB   = 0;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        COMMIT
    } state_t;

endpackage

// File: rtl/spi_reg_capture_if.sv
// SPI pin inputs and register-file / strobe outputs of the capture stage.
interface spi_reg_capture_if #(
    parameter int unsigned NUM_REGS = 5,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ADDR_W   = 7
);
    logic                       sclk;
    logic                       copi;
    logic                       ncs;
    logic [NUM_REGS*DATA_W-1:0] regs_o;
    logic                       wr_valid;
    logic [ADDR_W-1:0]          wr_addr;
    logic [DATA_W-1:0]          wr_data;
    logic                       frame_err;

    modport slave (
        input  sclk, copi, ncs,
        output regs_o, wr_valid, wr_addr, wr_data, frame_err
    );

    modport master (
        output sclk, copi, ncs,
        input  regs_o, wr_valid, wr_addr, wr_data, frame_err
    );
endinterface

// File: rtl/spi_reg_capture_sync_edge.sv
// Multi-stage synchronizer for one asynchronous pin with rise/fall detection on the synced level.
module sync_edge #(
    parameter int unsigned STAGES  = 2,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic level,
    output logic rise_c,
    output logic fall_c
);

    logic [STAGES-1:0] chain;
    logic              prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= {STAGES{RST_VAL}};
            prev  <= RST_VAL;
        end else begin
            chain <= {chain[STAGES-2:0], d};
            prev  <= chain[STAGES-1];
        end
    end

    assign level  = chain[STAGES-1];
    assign rise_c = level & ~prev;
    assign fall_c = ~level & prev;

endmodule

// File: rtl/spi_reg_capture.sv
// SPI mode-0 write-frame deserializer feeding a small register file in the clk domain.
module spi_reg_capture
    import spi_reg_pkg::*;
#(
    parameter int unsigned NUM_REGS    = 5,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned ADDR_W      = 7,
    parameter int unsigned SYNC_STAGES = 2
) (
    input logic              clk,
    input logic              rst,
    spi_reg_capture_if.slave bus
);

    logic sclk_lvl, sclk_rise, sclk_fall;
    logic copi_lvl, copi_rise, copi_fall;
    logic ncs_lvl,  ncs_rise,  ncs_fall;
    logic unused_edges;

    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst(rst), .d(bus.sclk),
        .level(sclk_lvl), .rise_c(sclk_rise), .fall_c(sclk_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_copi (
        .clk(clk), .rst(rst), .d(bus.copi),
        .level(copi_lvl), .rise_c(copi_rise), .fall_c(copi_fall)
    );

    // ncs resets low so a chip select held low through reset shows no falling edge
    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_ncs (
        .clk(clk), .rst(rst), .d(bus.ncs),
        .level(ncs_lvl), .rise_c(ncs_rise), .fall_c(ncs_fall)
    );

    assign unused_edges = ^{sclk_lvl, sclk_fall, copi_rise, copi_fall};

    state_t                     state;
    logic [FRAME_BITS-1:0]      shreg;
    logic [CNT_W-1:0]           cnt;
    logic [NUM_REGS*DATA_W-1:0] regs;
    logic                       wr_valid;
    logic                       frame_err;
    logic [ADDR_W-1:0]          wr_addr;
    logic [DATA_W-1:0]          wr_data;

    logic              frame_rw;
    logic [ADDR_W-1:0] frame_addr;
    logic [DATA_W-1:0] frame_data;

    assign frame_rw   = shreg[RW_BIT];
    assign frame_addr = shreg[ADDR_LSB +: ADDR_W];
    assign frame_data = shreg[DATA_LSB +: DATA_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            shreg     <= '0;
            cnt       <= '0;
            regs      <= '0;
            wr_valid  <= 1'b0;
            frame_err <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
        end else begin
            wr_valid  <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    shreg <= '0;
                    cnt   <= '0;
                    if (ncs_fall) state <= ACTIVE;
                end
                ACTIVE: begin
                    if (ncs_rise) begin
                        state <= COMMIT;
                    end else if (sclk_rise && !ncs_lvl) begin
                        // shifting stops at a full frame; the count keeps going to flag overrun
                        if (cnt < CNT_W'(FRAME_BITS)) shreg <= {shreg[FRAME_BITS-2:0], copi_lvl};
                        if (cnt < CNT_W'(CNT_SAT))    cnt   <= cnt + CNT_W'(1);
                    end
                end
                COMMIT: begin
                    state <= IDLE;
                    if (cnt == CNT_W'(FRAME_BITS)) begin
                        if (frame_rw == RW_WRITE && 32'(frame_addr) < NUM_REGS) begin
                            for (int unsigned n = 0; n < NUM_REGS; n++) begin
                                if (32'(frame_addr) == n) regs[n*DATA_W +: DATA_W] <= frame_data;
                            end
                            wr_valid <= 1'b1;
                            wr_addr  <= frame_addr;
                            wr_data  <= frame_data;
                        end
                    end else begin
                        frame_err <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.regs_o    = regs;
    assign bus.wr_valid  = wr_valid;
    assign bus.wr_addr   = wr_addr;
    assign bus.wr_data   = wr_data;
    assign bus.frame_err = frame_err;

endmodule

// File: doc/spi_reg_capture.md
# spi_reg_capture

Clock-domain SPI write-capture stage sitting between the SPI pins (SCLK, COPI, nCS on `ui_in[2:0]`) and the PWM peripheral's control inputs. Brings all three pins into the `clk` domain through synchronizers and deserializes 16-bit mode-0 frames. Commits write frames into a small register file whose outputs drive the PWM enable and duty-cycle inputs directly. Also emits a one-cycle write strobe and a framing-error strobe for debug and observability.

## Interface
- `NUM_REGS`, 5: number of writable registers (addresses 0..NUM_REGS-1)
- `DATA_W`, 8: register width
- `ADDR_W`, 7: address field width in the frame
- `SYNC_STAGES`, 2: flip-flop stages per synchronizer (≥2)
- `clk` in 1: system clock, the single clock of the block
- `rst` in 1: synchronous, active-high reset
- `sclk` in 1: raw SPI clock pin (mode 0, asynchronous to `clk`)
- `copi` in 1: raw SPI data-in pin
- `ncs` in 1: raw SPI chip select, active low
- `regs_o` out NUM_REGS*DATA_W: register file; reg n occupies bits [n*DATA_W +: DATA_W]
- `wr_valid` out 1: one-cycle pulse on every committed write
- `wr_addr` out ADDR_W: address of last committed write (held)
- `wr_data` out DATA_W: data of last committed write (held)
- `frame_err` out 1: one-cycle pulse when a frame ends with bit count ≠ 16

## Operation
- Synchronizers: each pin passes through SYNC_STAGES FFs, plus one "previous" FF for edge detection. Reset values: sclk chain 0, copi chain 0, ncs chain **0**. This makes an ncs held low through reset produce no falling edge.
- Frame: 16 bits, MSB first, sampled on synced SCLK rising edges. Bit 15 = R/W (1 = write), bits 14:8 = address, bits 7:0 = data.
- States:
  - IDLE: shift register and count cleared. Synced ncs falling edge → ACTIVE.
  - ACTIVE: each synced sclk rising edge while ncs low shifts in synced copi and increments the bit count. The count saturates at 17, and shifting stops after 16 bits. Synced ncs rising edge → COMMIT.
  - COMMIT (one cycle): evaluate the frame, then → IDLE.
- Commit rules:
  - count == 16, R/W = 1, address < NUM_REGS: write data to that register; pulse `wr_valid`; update `wr_addr`/`wr_data`.
  - count == 16, R/W = 0: no write, no error (reads not supported).
  - count == 16, address ≥ NUM_REGS: no write, no error.
  - count ≠ 16 (including 0 and ≥17): pulse `frame_err`, no write.
- SCLK edges while in IDLE or COMMIT are ignored.
- ncs rising edge in IDLE is ignored.
- Registers retain their values until overwritten or reset.

## Timing
- Reset: all registers 0, `regs_o` = 0, `wr_valid` = 0, `frame_err` = 0, `wr_addr` = 0, `wr_data` = 0, state IDLE.
- Reset mid-frame discards the partial frame. A fresh ncs falling edge is required before the next capture.
- Pin-to-sync latency: SYNC_STAGES clk edges.
- Commit latency: if edge k is the first `clk` edge that samples the raw ncs high:
  - edge k+SYNC_STAGES enters COMMIT;
  - edge k+SYNC_STAGES+1 updates `regs_o` and raises `wr_valid`/`frame_err` for exactly one cycle.
- Minimum SPI timing:
  - f_clk ≥ 6·f_sclk; SCLK high and low phases each ≥ 3 clk periods;
  - ncs high time between frames ≥ SYNC_STAGES+3 clk periods;
  - COPI stable ≥ 1 clk period before and after each SCLK rise.
- Back-to-back frames that meet the ncs high-time rule must all commit. No frame is dropped.

## Structure
- Package `spi_reg_pkg`:
  - `FRAME_BITS` = 16, `RW_WRITE` = 1'b1;
  - state enum (IDLE, ACTIVE, COMMIT);
  - frame field bit positions.
- Sub-module `sync_edge`: parameterized SYNC_STAGES synchronizer with reset value, plus rise/fall pulse outputs. Instantiated once per pin. Only the level output is used for copi.
- Top: FSM, 16-bit shift register, 5-bit saturating counter, register file.

## Test plan
- Write 0x01 to addr 0, then 0xA5 to addr 4 → `regs_o[7:0]` = 0x01, `regs_o[39:32]` = 0xA5. Each write produces one `wr_valid` pulse with the matching `wr_addr`/`wr_data`. Commit occurs SYNC_STAGES+1 edges after the ncs rise.
- Write 0x7F to addr 5, then a read frame (R/W = 0) to addr 2 → all registers unchanged, no `wr_valid`, no `frame_err`.
- ncs raised after 15 bits, then after 17 bits → one `frame_err` pulse each, registers unchanged. A following valid write to addr 1 = 0x3C succeeds.
- Assert `rst` mid-frame after 8 bits with regs preloaded, keep ncs low after deassert, finish clocking → all regs 0, no commit on the ncs rise. The next full frame commits.
- Five back-to-back writes (addr 0..4, data 0x10..0x14) at f_clk = 6·f_sclk with minimum ncs gap → exactly 5 `wr_valid` pulses, and `regs_o` = 0x1413121110.
- Randomized COPI toggling while ncs is high → no state change, no strobes.
